bus_rr_arbiter: RTL

- N-master to 1-slave arbiter on the core's req/gnt/rvalid data bus.
- Sits directly upstream of sim_ctrl and the other single-port peripherals, so core LSU, debug module and DMA can share one slave port.
- Round-robin grant; outstanding-transaction ID FIFO routes each slave rvalid/rdata back to the master that issued the request.

---
 rtl/bus_arb_pkg.sv | 25 ++
 rtl/bus_arb_id_fifo.sv | 66 ++++++
 rtl/bus_rr_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared widths, ID-width helper and per-master request payload for bus_rr_arbiter.
package bus_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_arb_id_fifo.sv
// Synchronous FIFO of master IDs for outstanding slave transactions.
// Head is visible combinationally; push and pop may occur in the same cycle, even when full.
module bus_arb_id_fifo
  import bus_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ID_W  = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [ID_W-1:0] id_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [ID_W-1:0] head_o
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = clog2_min1(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is left unreset; only entries below the occupancy count are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= id_i;
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// N-master to 1-slave req/gnt/rvalid arbiter with in-order response routing by ID FIFO.
// Define BUS_ARB_FIXED_PRIO_EN for fixed lowest-index priority; BUS_ARB_ASSERT_ON enables the stray-rvalid check.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  output logic [NUM_MASTERS-1:0]        m_gnt_o,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_be_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]        m_rvalid_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic                          s_req_o,
  input  logic                          s_gnt_i,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic                          s_we_o,
  output logic [BE_W-1:0]               s_be_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  input  logic                          s_rvalid_i,
  input  logic [DATA_W-1:0]             s_rdata_i
);

  localparam int ID_W = clog2_min1(NUM_MASTERS);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_MASTERS - 1);
  localparam logic [ID_W:0]   NM_C    = (ID_W + 1)'(NUM_MASTERS);

  bus_req_t        req_arr [NUM_MASTERS];
  bus_req_t        sel_req;
  logic [ID_W-1:0] rr_ptr, winner, cand, mux_sel, fifo_head;
  logic [ID_W-1:0] last_sel_q, last_sel_d;
  logic [ID_W:0]   scan;
  logic            found, sel_vld_q, sel_vld_d, err_q, err_d;
  logic            fifo_full, fifo_empty, pop, full_gate, hs;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign req_arr[gi].addr  = m_addr_i[gi*ADDR_W +: ADDR_W];
      assign req_arr[gi].we    = m_we_i[gi];
      assign req_arr[gi].be    = m_be_i[gi*BE_W +: BE_W];
      assign req_arr[gi].wdata = m_wdata_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    scan   = '0;
    cand   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      scan = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (scan >= NM_C) scan = scan - NM_C;
      cand = scan[ID_W-1:0];
      if (!found && m_req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // A response arriving this cycle frees its slot before the request gate looks at occupancy.
  assign pop       = s_rvalid_i & ~fifo_empty;
  assign full_gate = fifo_full & ~pop;
  assign s_req_o   = rst_ni & (|m_req_i) & ~full_gate;
  assign hs        = s_req_o & s_gnt_i;

  assign m_gnt_o    = hs  ? (NUM_MASTERS'(1) << winner)    : '0;
  assign m_rvalid_o = pop ? (NUM_MASTERS'(1) << fifo_head) : '0;
  assign m_rdata_o  = s_rdata_i;

  assign mux_sel = s_req_o ? winner : last_sel_q;

  always_comb begin
    sel_req = '0;
    if (s_req_o || sel_vld_q) sel_req = req_arr[mux_sel];
  end

  assign s_addr_o  = sel_req.addr;
  assign s_we_o    = sel_req.we;
  assign s_be_o    = sel_req.be;
  assign s_wdata_o = sel_req.wdata;

  assign last_sel_d = s_req_o ? winner : last_sel_q;
  assign sel_vld_d  = sel_vld_q | s_req_o;
  assign err_d      = err_q | (s_rvalid_i & fifo_empty);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_sel_q <= '0;
      sel_vld_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      last_sel_q <= last_sel_d;
      sel_vld_q  <= sel_vld_d;
      err_q      <= err_d;
    end
  end

`ifdef BUS_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) rr_ptr_d = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`endif

  bus_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (ID_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .id_i    (winner),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

`ifdef BUS_ARB_ASSERT_ON
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(s_rvalid_i && fifo_empty))
        else $error("bus_rr_arbiter: slave response with no outstanding transaction");
    end
  end
`endif

endmodule
